// File: rtl/rv32_dbg_pkg.sv
// Shared encodings for the RV32 debug memory loader: command opcodes, FSM states, BRAM sizing.
package rv32_dbg_pkg;

  localparam int BRAMWORDS = 4096;
  localparam int NWORDS_W  = 13;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_DUMP = 2'b01,
    OP_RUN  = 2'b10,
    OP_RSVD = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DUMP_ADDR,
    S_DUMP_WAIT,
    S_DUMP_OUT,
    S_RUN
  } state_e;

  // A count of zero, or one larger than the BRAM, means "the whole BRAM".
  function automatic logic [NWORDS_W-1:0] eff_nwords(input logic [NWORDS_W-1:0] n, input int words);
    if (n == '0 || int'(n) > words) return NWORDS_W'(words);
    return n;
  endfunction

endpackage

// File: rtl/rv32_debug_mem_loader_if.sv
// Host command/stream bundle and BRAM debug-port bundle used by the loader.
interface rv32_dbg_host_if;
  logic                              cmd_valid;
  logic                              cmd_ready;
  logic [1:0]                        cmd_op;
  logic                              cmd_sel;
  logic [rv32_dbg_pkg::NWORDS_W-1:0] cmd_nwords;
  logic                              in_valid;
  logic                              in_ready;
  logic [31:0]                       in_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [31:0]                       out_data;
  logic                              out_last;

  modport master (
    output cmd_valid, cmd_op, cmd_sel, cmd_nwords, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, cmd_nwords, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, out_last
  );
endinterface

interface rv32_dbg_bram_if;
  logic [31:0] a2;
  logic [31:0] wd2;
  logic [3:0]  we2;
  logic [31:0] rd2;

  modport master (output a2, wd2, we2, input rd2);
  modport slave  (input a2, wd2, we2, output rd2);
endinterface

// File: rtl/rv32_dbg_port_mux.sv
// Routes the loader's address/write strobe to the DataRAM or InstRAM debug port and muxes rd2 back.
module rv32_dbg_port_mux (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        drive,
  input  logic        wr,
  input  logic [31:0] a2,
  input  logic [31:0] wd2,
  output logic [31:0] rd2,
  rv32_dbg_bram_if.master dram,
  rv32_dbg_bram_if.master iram
);

  // Port 0 is DataRAM, port 1 is InstRAM; an unselected port keeps its last address.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam logic PORT_SEL = (gi == 1);
    logic [31:0] a2_reg;
    logic [31:0] wd2_reg;
    logic [3:0]  we2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a2_reg  <= '0;
        wd2_reg <= '0;
        we2_reg <= '0;
      end else begin
        we2_reg <= '0;
        if (drive && (sel == PORT_SEL)) begin
          a2_reg <= a2;
          if (wr) begin
            wd2_reg <= wd2;
            we2_reg <= 4'hF;
          end
        end
      end
    end
  end

  assign dram.a2  = g_port[0].a2_reg;
  assign dram.wd2 = g_port[0].wd2_reg;
  assign dram.we2 = g_port[0].we2_reg;
  assign iram.a2  = g_port[1].a2_reg;
  assign iram.wd2 = g_port[1].wd2_reg;
  assign iram.we2 = g_port[1].we2_reg;

  assign rd2 = sel ? iram.rd2 : dram.rd2;

endmodule

// File: rtl/rv32_debug_mem_loader.sv
// Host-side load/run/dump controller for the RV32Core debug BRAM ports; holds the core in reset
// except during a bounded RUN window.
module rv32_debug_mem_loader #(
  parameter int BRAMWORDS  = rv32_dbg_pkg::BRAMWORDS,
  parameter int RD_LAT     = 1,
  parameter int RUN_CYCLES = 200000
) (
  input  logic CPU_CLK,
  input  logic CPU_RSTN,
  rv32_dbg_host_if.slave  host,
  rv32_dbg_bram_if.master dram,
  rv32_dbg_bram_if.master iram,
  output logic core_rst,
  output logic busy,
  output logic done
);
  import rv32_dbg_pkg::*;

  localparam int IDX_W  = $clog2(BRAMWORDS);
  localparam int WAIT_W = $clog2(RD_LAT + 1) + 1;
  localparam int RUN_W  = $clog2(RUN_CYCLES) + 1;

  state_e            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [IDX_W-1:0]  last_reg;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [RUN_W-1:0]  run_reg, run_next;
  logic              sel_reg;
  logic              cmd_ready_reg;
  logic              core_rst_reg;
  logic              done_reg, done_next;
  logic [31:0]       out_data_reg;
  logic              out_last_reg;
  logic              accept, drive, wr, capture;
  logic [31:0]       rd2;

  assign accept = host.cmd_valid && cmd_ready_reg;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    wait_next  = wait_reg;
    run_next   = run_reg;
    drive      = 1'b0;
    wr         = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          idx_next = '0;
          run_next = '0;
          case (cmd_op_e'(host.cmd_op))
            OP_LOAD: state_next = S_LOAD;
            OP_DUMP: state_next = S_DUMP_ADDR;
            OP_RUN:  state_next = S_RUN;
            default: state_next = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        if (host.in_valid) begin
          drive = 1'b1;
          wr    = 1'b1;
          if (idx_reg == last_reg) state_next = S_IDLE;
          else                     idx_next   = idx_reg + 1'b1;
        end
      end
      S_DUMP_ADDR: begin
        drive      = 1'b1;
        wait_next  = '0;
        state_next = S_DUMP_WAIT;
      end
      // The port mux registers the address, so rd2 is valid RD_LAT cycles after this state begins.
      S_DUMP_WAIT: begin
        if (wait_reg == WAIT_W'(RD_LAT)) begin
          capture    = 1'b1;
          state_next = S_DUMP_OUT;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      S_DUMP_OUT: begin
        if (host.out_ready) begin
          if (idx_reg == last_reg) begin
            state_next = S_IDLE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = S_DUMP_ADDR;
          end
        end
      end
      S_RUN: begin
        if (run_reg == RUN_W'(RUN_CYCLES - 1)) state_next = S_IDLE;
        else                                   run_next   = run_reg + 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
    // Reserved opcodes never leave IDLE but still report completion.
    done_next = (state_reg != S_IDLE || accept) && (state_next == S_IDLE);
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RSTN) begin
    if (!CPU_RSTN) begin
      state_reg     <= S_IDLE;
      idx_reg       <= '0;
      last_reg      <= '0;
      wait_reg      <= '0;
      run_reg       <= '0;
      sel_reg       <= 1'b0;
      cmd_ready_reg <= 1'b0;
      core_rst_reg  <= 1'b1;
      done_reg      <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      wait_reg      <= wait_next;
      run_reg       <= run_next;
      cmd_ready_reg <= (state_next == S_IDLE);
      core_rst_reg  <= (state_next != S_RUN);
      done_reg      <= done_next;
      if (accept) begin
        sel_reg  <= host.cmd_sel;
        last_reg <= IDX_W'(eff_nwords(host.cmd_nwords, BRAMWORDS) - NWORDS_W'(1));
      end
      if (capture) begin
        out_data_reg <= rd2;
        out_last_reg <= (idx_reg == last_reg);
      end
    end
  end

  rv32_dbg_port_mux u_port_mux (
    .clk   (CPU_CLK),
    .rst_n (CPU_RSTN),
    .sel   (sel_reg),
    .drive (drive),
    .wr    (wr),
    .a2    (32'({idx_reg, 2'b00})),
    .wd2   (host.in_data),
    .rd2   (rd2),
    .dram  (dram),
    .iram  (iram)
  );

  assign host.cmd_ready = cmd_ready_reg;
  assign host.in_ready  = (state_reg == S_LOAD);
  assign host.out_valid = (state_reg == S_DUMP_OUT);
  assign host.out_data  = out_data_reg;
  assign host.out_last  = (state_reg == S_DUMP_OUT) && out_last_reg;
  assign core_rst       = core_rst_reg;
  assign busy           = (state_reg != S_IDLE);
  assign done           = done_reg;

endmodule

// File: tb/tb_rv32_debug_mem_loader.sv
// Bench for rv32_debug_mem_loader: hand sequences for the corner cases, then a command table
// with random data and stalls checked against a word-array memory model.
module tb_rv32_debug_mem_loader;
  import rv32_dbg_pkg::*;

  localparam int BW   = 64;
  localparam int IW   = 6;
  localparam int RUNC = 10;

  typedef struct {
    logic [1:0]  op;
    logic        sel;
    logic [12:0] nwords;
    int          exp_n;
    int          exp_low;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  we;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic core_rst, busy, done;

  rv32_dbg_host_if host ();
  rv32_dbg_bram_if dram_if ();
  rv32_dbg_bram_if iram_if ();

  rv32_debug_mem_loader #(
    .BRAMWORDS  (BW),
    .RD_LAT     (1),
    .RUN_CYCLES (RUNC)
  ) dut (
    .CPU_CLK  (clk),
    .CPU_RSTN (rst_n),
    .host     (host),
    .dram     (dram_if),
    .iram     (iram_if),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [2][BW];
  logic [31:0] ref_mem [2][BW];
  logic [31:0] ldq [$];
  wr_t         wlog [$];
  int          done_cnt = 0;
  int          low_cnt  = 0;
  int          n_vec    = 0;
  int          n_err    = 0;

  // BRAM pair with one-cycle registered read, plus write/done/run monitors.
  always @(posedge clk) begin
    if (dram_if.we2 == 4'hF) mem[0][dram_if.a2[IW+1:2]] <= dram_if.wd2;
    if (iram_if.we2 == 4'hF) mem[1][iram_if.a2[IW+1:2]] <= iram_if.wd2;
    dram_if.rd2 <= mem[0][dram_if.a2[IW+1:2]];
    iram_if.rd2 <= mem[1][iram_if.a2[IW+1:2]];
    if (dram_if.we2 != 4'h0) wlog.push_back('{port: 1'b0, a: dram_if.a2, d: dram_if.wd2, we: dram_if.we2});
    if (iram_if.we2 != 4'h0) wlog.push_back('{port: 1'b1, a: iram_if.a2, d: iram_if.wd2, we: iram_if.we2});
    if (done) done_cnt++;
    if (!core_rst) low_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic sel, input logic [12:0] nw);
    int c = 0;
    @(negedge clk);
    while (!host.cmd_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("cmd_ready", 32'(host.cmd_ready), 32'd1);
    host.cmd_valid  = 1'b1;
    host.cmd_op     = op;
    host.cmd_sel    = sel;
    host.cmd_nwords = nw;
    @(negedge clk);
    host.cmd_valid = 1'b0;
  endtask

  task automatic run_load(input int n, input int mode);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      host.in_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      host.in_data  = ldq[k];
      if (host.in_valid && host.in_ready) k++;
    end
    @(negedge clk);
    host.in_valid = 1'b0;
    chk("load_accepts", k, n);
  endtask

  task automatic run_dump(input logic sel, input int n, input int mode);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (mode == 0)      host.out_ready = 1'b1;
      else if (mode == 2) host.out_ready = cyc[0];
      else                host.out_ready = ($urandom_range(0, 3) != 0);
      if (host.out_valid) begin
        chk("dump_data", host.out_data, ref_mem[sel][got]);
        if (host.out_ready) begin
          chk("dump_last", 32'(host.out_last), 32'(got == n - 1));
          got++;
        end
      end
    end
    @(negedge clk);
    host.out_ready = 1'b0;
    chk("dump_words", got, n);
  endtask

  task automatic wait_idle();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((busy || !host.cmd_ready) && c < 2000);
    chk("idle", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic sel, input logic [12:0] nw,
                        input int exp_n, input int exp_low, input int mode, input bit fill);
    @(negedge clk);
    wlog.delete();
    done_cnt = 0;
    low_cnt  = 0;
    if (fill) begin
      ldq.delete();
      for (int i = 0; i < exp_n; i++) ldq.push_back($urandom);
    end
    $display("cmd op=%0d sel=%0d nwords=%0d expect_words=%0d mode=%0d", op, sel, nw, exp_n, mode);
    send_cmd(op, sel, nw);
    if (op == OP_LOAD)      run_load(exp_n, mode);
    else if (op == OP_DUMP) run_dump(sel, exp_n, mode);
    wait_idle();
    if (op == OP_LOAD)
      for (int i = 0; i < exp_n; i++) ref_mem[sel][i] = ldq[i];
    chk("wr_count", wlog.size(), (op == OP_LOAD) ? exp_n : 0);
    for (int i = 0; i < wlog.size() && i < exp_n; i++) begin
      chk("wr_port", 32'(wlog[i].port), 32'(sel));
      chk("wr_addr", wlog[i].a, 32'(4 * i));
      chk("wr_data", wlog[i].d, ldq[i]);
      chk("wr_be", 32'(wlog[i].we), 32'hF);
    end
    chk("done_pulses", done_cnt, 1);
    chk("run_low", low_cnt, exp_low);
    chk("core_rst_idle", 32'(core_rst), 32'd1);
  endtask

  initial begin
    vec_t tbl [11];
    tbl[0]  = '{OP_LOAD, 1'b0, 13'd5,   5,  0};
    tbl[1]  = '{OP_LOAD, 1'b1, 13'd7,   7,  0};
    tbl[2]  = '{OP_DUMP, 1'b0, 13'd5,   5,  0};
    tbl[3]  = '{OP_DUMP, 1'b1, 13'd7,   7,  0};
    tbl[4]  = '{OP_LOAD, 1'b0, 13'd0,   64, 0};
    tbl[5]  = '{OP_DUMP, 1'b0, 13'd100, 64, 0};
    tbl[6]  = '{OP_RUN,  1'b0, 13'd9,   0,  RUNC};
    tbl[7]  = '{OP_RSVD, 1'b1, 13'd3,   0,  0};
    tbl[8]  = '{OP_LOAD, 1'b1, 13'd64,  64, 0};
    tbl[9]  = '{OP_DUMP, 1'b1, 13'd1,   1,  0};
    tbl[10] = '{OP_DUMP, 1'b1, 13'd65,  64, 0};

    for (int i = 0; i < BW; i++) begin
      mem[0][i] = '0;
      mem[1][i] = '0;
      ref_mem[0][i] = '0;
      ref_mem[1][i] = '0;
    end
    host.cmd_valid  = 1'b0;
    host.cmd_op     = 2'b00;
    host.cmd_sel    = 1'b0;
    host.cmd_nwords = '0;
    host.in_valid   = 1'b0;
    host.in_data    = '0;
    host.out_ready  = 1'b0;

    // Reset values, then cmd_ready only after the first clock in IDLE.
    $display("reset state check");
    repeat (3) @(negedge clk);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cmd_ready", 32'(host.cmd_ready), 32'd0);
    chk("rst_in_ready", 32'(host.in_ready), 32'd0);
    chk("rst_out_valid", 32'(host.out_valid), 32'd0);
    chk("rst_out_last", 32'(host.out_last), 32'd0);
    chk("rst_dram_a2", dram_if.a2, 32'd0);
    chk("rst_dram_we2", 32'(dram_if.we2), 32'd0);
    chk("rst_iram_wd2", iram_if.wd2, 32'd0);
    chk("rst_iram_we2", 32'(iram_if.we2), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("cmd_ready_pre_clk", 32'(host.cmd_ready), 32'd0);
    @(negedge clk);
    chk("cmd_ready_idle", 32'(host.cmd_ready), 32'd1);

    ldq = '{32'd11, 32'd22, 32'd33};
    do_cmd(OP_LOAD, 1'b0, 13'd3, 3, 0, 0, 1'b0);
    chk("we2_drop", 32'(dram_if.we2), 32'd0);

    ldq = '{32'hCAFE_0001, 32'hCAFE_0002};
    do_cmd(OP_LOAD, 1'b1, 13'd2, 2, 0, 1, 1'b0);

    do_cmd(OP_DUMP, 1'b0, 13'd3, 3, 0, 2, 1'b0);
    do_cmd(OP_RUN, 1'b0, 13'd0, 0, RUNC, 0, 1'b0);

    do_cmd(OP_DUMP, 1'b0, 13'd0, BW, 0, 0, 1'b0);
    chk("dump_last_a2", dram_if.a2, 32'(4 * BW - 4));

    // Abort a load after two words have been written.
    ldq = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004};
    $display("cmd op=0 sel=0 nwords=4 reset after word 2");
    send_cmd(OP_LOAD, 1'b0, 13'd4);
    run_load(2, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_we2", 32'(dram_if.we2), 32'd0);
    chk("abort_core_rst", 32'(core_rst), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(host.in_ready), 32'd0);
    ref_mem[0][0] = ldq[0];
    ref_mem[0][1] = ldq[1];
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(OP_DUMP, 1'b0, 13'd4, 4, 0, 0, 1'b0);
    ldq = '{32'h0BAD_F00D, 32'h1234_5678};
    do_cmd(OP_LOAD, 1'b0, 13'd2, 2, 0, 0, 1'b0);

    for (int t = 0; t < 11; t++)
      do_cmd(tbl[t].op, tbl[t].sel, tbl[t].nwords, tbl[t].exp_n, tbl[t].exp_low, 1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
